risc_v_mc: RTL and testbench

RISC_V_MC -- requirements
Module: risc_v_mc

---
 rtl/risc_v_mc.sv | 176 +++++++++++++++++
 tb/tb_risc_v_mc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_v_mc.sv
// risc_v_mc: multi-cycle RV32I-subset core (lw/sw, add/sub/and/or/xor/slt, beq/bne, jal, lui).
// Define RISC_V_MC_JALR_EN to add jalr; without it opcode 1100111 traps like any other unknown opcode.
module risc_v_mc #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMEM_ADDR_WIDTH = 8,
  parameter int DMEM_ADDR_WIDTH = 9,
  parameter int RESET_PC        = 0,
  parameter     IMEM_FILE       = "program.hex"
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic [DATA_WIDTH-1:0] a0,
  output logic                  InstrDone,
  output logic                  Illegal
);

  localparam int IMEM_WORDS = 2 ** (IMEM_ADDR_WIDTH - 2);
  localparam int DMEM_WORDS = 2 ** (DMEM_ADDR_WIDTH - 2);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, LUI,
`ifdef RISC_V_MC_JALR_EN
    JALR,
`endif
    TRAP
  } state_t;

  state_t                     state, next_state;
  logic [IMEM_ADDR_WIDTH-1:0] pc, old_pc;
  logic [31:0]                ir;
  logic [DATA_WIDTH-1:0]      a, b, alu_out, mdr;
  logic [DATA_WIDTH-1:0]      regs [32];
  logic [31:0]                imem [IMEM_WORDS];
  logic [DATA_WIDTH-1:0]      dmem [DMEM_WORDS];

  logic [6:0]                 opcode;
  logic [4:0]                 rd, rs1, rs2;
  logic [2:0]                 funct3;
  logic [DATA_WIDTH-1:0]      imm_i, imm_s, imm_b, imm_j, old_pc_ext, rs1_val, rs2_val;
  logic                       br_taken;
  logic [DMEM_ADDR_WIDTH-3:0] dmem_idx;
  logic                       rf_we;
  logic [DATA_WIDTH-1:0]      rf_wd;

  assign opcode     = ir[6:0];
  assign rd         = ir[11:7];
  assign funct3     = ir[14:12];
  assign rs1        = ir[19:15];
  assign rs2        = ir[24:20];
  assign imm_i      = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
  assign imm_s      = {{(DATA_WIDTH-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b      = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j      = {{(DATA_WIDTH-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign old_pc_ext = {{(DATA_WIDTH-IMEM_ADDR_WIDTH){1'b0}}, old_pc};
  assign rs1_val    = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val    = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign br_taken   = funct3[0] ? (a != b) : (a == b);
  assign dmem_idx   = alu_out[DMEM_ADDR_WIDTH-1:2];
  assign a0         = regs[10];

  function automatic logic [DATA_WIDTH-1:0] alu(input logic [DATA_WIDTH-1:0] x,
                                                input logic [DATA_WIDTH-1:0] y,
                                                input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? x - y : x + y;
      3'b010:  return DATA_WIDTH'($signed(x) < $signed(y));
      3'b100:  return x ^ y;
      3'b110:  return x | y;
      3'b111:  return x & y;
      default: return x + y;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: next_state = MEMADR;
          7'b0110011:             next_state = EXECR;
          7'b0010011:             next_state = EXECI;
          // Invalid branch conditions trap here so BRANCH always retires.
          7'b1100011:             next_state = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
          7'b1101111:             next_state = JAL;
          7'b0110111:             next_state = LUI;
`ifdef RISC_V_MC_JALR_EN
          7'b1100111:             next_state = JALR;
`endif
          default:                next_state = TRAP;
        endcase
      end
      MEMADR:              next_state = opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD:             next_state = MEMWB;
      EXECR, EXECI, JAL:   next_state = ALUWB;
      TRAP:                next_state = TRAP;
      default:             next_state = FETCH;
    endcase
  end

  always_comb begin
    InstrDone = 1'b0;
    rf_we     = 1'b0;
    rf_wd     = '0;
    case (state)
      MEMWB:    begin InstrDone = 1'b1; rf_we = 1'b1; rf_wd = mdr; end
      ALUWB:    begin InstrDone = 1'b1; rf_we = 1'b1; rf_wd = alu_out; end
      LUI:      begin InstrDone = 1'b1; rf_we = 1'b1; rf_wd = DATA_WIDTH'({ir[31:12], 12'b0}); end
`ifdef RISC_V_MC_JALR_EN
      JALR:     begin InstrDone = 1'b1; rf_we = 1'b1; rf_wd = old_pc_ext + DATA_WIDTH'(4); end
`endif
      MEMWRITE, BRANCH: InstrDone = 1'b1;
      default:  ;
    endcase
  end

  assign Illegal = (state == TRAP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc      <= IMEM_ADDR_WIDTH'(RESET_PC);
      old_pc  <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir     <= imem[pc[IMEM_ADDR_WIDTH-1:2]];
          old_pc <= pc;
          pc     <= pc + IMEM_ADDR_WIDTH'(4);
        end
        DECODE: begin
          a       <= rs1_val;
          b       <= rs2_val;
          alu_out <= old_pc_ext + imm_b;
        end
        MEMADR:  alu_out <= a + (opcode[5] ? imm_s : imm_i);
        MEMREAD: mdr <= dmem[dmem_idx];
        EXECR:   alu_out <= alu(a, b, funct3, ir[30]);
        EXECI:   alu_out <= alu(a, imm_i, funct3, 1'b0);
        BRANCH:  if (br_taken) pc <= IMEM_ADDR_WIDTH'(alu_out);
        JAL: begin
          pc      <= IMEM_ADDR_WIDTH'(old_pc_ext + imm_j);
          alu_out <= old_pc_ext + DATA_WIDTH'(4);
        end
`ifdef RISC_V_MC_JALR_EN
        JALR:    pc <= IMEM_ADDR_WIDTH'((a + imm_i) & ~DATA_WIDTH'(1));
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && rd != 5'd0) begin
      regs[rd] <= rf_wd;
    end
  end

  // Data memory has no reset so its contents survive RST.
  always_ff @(posedge CLK) begin
    if (state == MEMWRITE) dmem[dmem_idx] <= b;
  end

endmodule

// File: tb/tb_risc_v_mc.sv
// tb_risc_v_mc: directed and random programs for risc_v_mc, checked against an instruction-level model.
module tb_risc_v_mc;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] a0;
  logic        InstrDone;
  logic        Illegal;

  int n_checks = 0;
  int n_fail   = 0;

  risc_v_mc #(
    .DATA_WIDTH(32), .IMEM_ADDR_WIDTH(8), .DMEM_ADDR_WIDTH(9), .RESET_PC(0), .IMEM_FILE("")
  ) dut (
    .CLK(CLK), .RST(RST), .a0(a0), .InstrDone(InstrDone), .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  logic [31:0] prog  [64];
  int          m_x   [32];
  int          m_mem [128];
  int          m_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], rs2[4:0], rs1[4:0], 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], rs2[4:0], rs1[4:0], f3[2:0], v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], rd[4:0], 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], rd[4:0], 7'h37};
  endfunction

  function automatic int m_alu(input int x, input int y, input int f3, input int sub);
    case (f3)
      0:       return (sub != 0) ? x - y : x + y;
      2:       return (x < y) ? 1 : 0;
      4:       return x ^ y;
      6:       return x | y;
      7:       return x & y;
      default: return 0;
    endcase
  endfunction

  task automatic m_setr(input int rd, input int v);
    if (rd != 0) m_x[rd] = v;
  endtask

  // Executes one instruction on the model; returns its cycle count or flags a trap.
  task automatic m_step(output int cyc, output bit ill);
    int w, op, rd, f3, x1, x2, immi, imms, immb, immj, addr, nxt;
    w    = int'(prog[(m_pc >> 2) & 63]);
    op   = w & 127;
    rd   = (w >>> 7) & 31;
    f3   = (w >>> 12) & 7;
    x1   = m_x[(w >>> 15) & 31];
    x2   = m_x[(w >>> 20) & 31];
    immi = w >>> 20;
    imms = ((w >>> 25) << 5) | ((w >>> 7) & 31);
    immb = ((w >>> 31) << 12) | (((w >>> 7) & 1) << 11) | (((w >>> 25) & 63) << 5) | (((w >>> 8) & 15) << 1);
    immj = ((w >>> 31) << 20) | (w & 'hff000) | (((w >>> 20) & 1) << 11) | (((w >>> 21) & 1023) << 1);
    nxt  = m_pc + 4;
    ill  = 1'b0;
    cyc  = 0;
    case (op)
      'h03: begin addr = x1 + immi; m_setr(rd, m_mem[(addr >>> 2) & 127]); cyc = 5; end
      'h23: begin addr = x1 + imms; m_mem[(addr >>> 2) & 127] = x2; cyc = 4; end
      'h33: begin m_setr(rd, m_alu(x1, x2, f3, (w >>> 30) & 1)); cyc = 4; end
      'h13: begin m_setr(rd, m_alu(x1, immi, f3, 0)); cyc = 4; end
      'h63: begin
        if (f3 == 0 || f3 == 1) begin
          if ((f3 == 0) == (x1 == x2)) nxt = m_pc + immb;
          cyc = 3;
        end else ill = 1'b1;
      end
      'h6f: begin m_setr(rd, m_pc + 4); nxt = m_pc + immj; cyc = 4; end
      'h37: begin m_setr(rd, w & 'hfffff000); cyc = 3; end
`ifdef RISC_V_MC_JALR_EN
      'h67: begin m_setr(rd, m_pc + 4); nxt = (x1 + immi) & ~1; cyc = 3; end
`endif
      default: ill = 1'b1;
    endcase
    if (!ill) m_pc = nxt & 255;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = '0;
  endtask

  task automatic check_dmem(input string name);
    for (int i = 0; i < 128; i++) check({name, "_dmem"}, dut.dmem[i], m_mem[i]);
  endtask

  // Resets the core, loads prog, then steps DUT and model side by side.
  task automatic run(input string name, input int max_steps);
    int cyc, pc0;
    bit ill;
    RST = 1'b1;
    for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];
    for (int i = 0; i < 32; i++) m_x[i] = 0;
    m_pc = 0;
    @(negedge CLK);
    check({name, "_rst_a0"}, a0, 0);
    check({name, "_rst_illegal"}, Illegal, 0);
    check({name, "_rst_done"}, InstrDone, 0);
    check({name, "_rst_pc"}, dut.pc, 0);
    RST = 1'b0;
    for (int s = 0; s < max_steps; s++) begin
      pc0 = m_pc;
      m_step(cyc, ill);
      if (ill) begin
        for (int k = 0; k < 2; k++) begin
          check({name, "_trap_done"}, InstrDone, 0);
          @(negedge CLK);
        end
        check({name, "_trap_illegal"}, Illegal, 1);
        check({name, "_trap_pc"}, dut.pc, (pc0 + 4) & 255);
        for (int k = 0; k < 20; k++) begin
          check({name, "_trap_hold_done"}, InstrDone, 0);
          @(negedge CLK);
        end
        check({name, "_trap_hold_illegal"}, Illegal, 1);
        check({name, "_trap_hold_pc"}, dut.pc, (pc0 + 4) & 255);
        check({name, "_trap_a0"}, a0, m_x[10]);
        check_dmem(name);
        return;
      end
      for (int k = 1; k <= cyc; k++) begin
        check({name, "_done"}, InstrDone, k == cyc);
        @(negedge CLK);
      end
      check({name, "_a0"}, a0, m_x[10]);
      check({name, "_illegal"}, Illegal, 0);
    end
    check({name, "_pc_end"}, dut.pc, m_pc);
    check_dmem(name);
  endtask

  function automatic int rr();
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return 5;
      2:       return 6;
      3:       return 7;
      default: return 10;
    endcase
  endfunction

  function automatic int f3_pick();
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return 2;
      2:       return 4;
      3:       return 6;
      default: return 7;
    endcase
  endfunction

  task automatic gen_random(input int n);
    int f3, t;
    clear_prog();
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 9))
        0, 1: prog[i] = enc_i(int'($urandom_range(0, 4095)), rr(), f3_pick(), rr(), 7'h13);
        2, 3: begin
          f3 = f3_pick();
          prog[i] = enc_r((f3 == 0 && $urandom_range(0, 1) == 1) ? 32 : 0, rr(), rr(), f3, rr());
        end
        4: prog[i] = enc_u(int'($urandom), rr());
        5: prog[i] = enc_s(int'($urandom_range(0, 4095)), rr(), rr());
        6: prog[i] = enc_i(int'($urandom_range(0, 4095)), rr(), 2, rr(), 7'h03);
        7: begin
          t = int'($urandom_range(i + 1, n));
          f3 = ($urandom_range(0, 15) == 0) ? 4 : int'($urandom_range(0, 1));
          prog[i] = enc_b((t - i) * 4, rr(), rr(), f3);
        end
        8: begin
          t = int'($urandom_range(i + 1, n));
          prog[i] = enc_j((t - i) * 4, rr());
        end
        default: prog[i] = enc_i(int'($urandom_range(0, 4095)), rr(), 0, 10, 7'h13);
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) m_mem[i] = 0;

    // Zero all of data memory with a backward bne loop.
    clear_prog();
    prog[0] = enc_i(0, 0, 0, 5, 7'h13);
    prog[1] = enc_i(512, 0, 0, 6, 7'h13);
    prog[2] = enc_s(0, 0, 5);
    prog[3] = enc_i(4, 5, 0, 5, 7'h13);
    prog[4] = enc_b(-8, 6, 5, 1);
    run("dinit", 1000);

    clear_prog();
    prog[0] = enc_i(5, 0, 0, 10, 7'h13);
    prog[1] = enc_i(-3, 10, 0, 10, 7'h13);
    run("addi", 10);
    check("addi_final", a0, 32'd2);

    clear_prog();
    prog[0] = enc_i('h55, 0, 0, 5, 7'h13);
    prog[1] = enc_s(8, 5, 0);
    prog[2] = enc_i(8, 0, 2, 10, 7'h03);
    run("swlw", 10);
    check("swlw_final", a0, 32'h55);
    check("swlw_dmem2", dut.dmem[2], 32'h55);

    clear_prog();
    prog[0] = enc_b(8, 0, 0, 0);
    prog[1] = enc_i(9, 0, 0, 10, 7'h13);
    prog[2] = enc_b(8, 0, 0, 1);
    prog[3] = enc_i(1, 10, 0, 10, 7'h13);
    run("branch", 10);
    check("branch_final", a0, 32'd1);

    clear_prog();
    run("zero_word", 10);
    check("zero_word_pc", dut.pc, 32'd4);

    clear_prog();
    for (int i = 0; i < 4; i++) prog[i] = enc_i(0, 0, 0, 0, 7'h13);
    prog[4] = enc_i(0, 0, 0, 10, 7'h67);
    run("jalr", 5);
`ifdef RISC_V_MC_JALR_EN
    check("jalr_a0", a0, 32'h14);
    check("jalr_pc", dut.pc, 32'd0);
`else
    check("jalr_illegal", Illegal, 1'b1);
`endif

    // Reset asserted while the second addi sits in EXECI.
    clear_prog();
    prog[0] = enc_i(5, 0, 0, 10, 7'h13);
    prog[1] = enc_i(7, 10, 0, 10, 7'h13);
    run("rst_pre", 1);
    @(negedge CLK);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_a0", a0, 0);
    check("rst_mid_pc", dut.pc, 0);
    check("rst_mid_illegal", Illegal, 0);
    check("rst_mid_done", InstrDone, 0);
    run("rst_post", 10);
    check("rst_post_final", a0, 32'd12);

    for (int r = 0; r < 25; r++) begin
      gen_random(int'($urandom_range(8, 40)));
      run("rand", 200);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
